// File: rtl/fetch_unit_pkg.sv
// Shared core constants and the fetch-stage state encoding.
package fetch_unit_pkg;

  localparam logic [31:0] NOOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding word read per PC, result held for decode.
// Bus errors, misaligned PCs and response timeouts become a flagged NOOP.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  input  logic [31:0] i_PC,
  input  logic        i_DECODE_READY,
  output logic        o_IMEM_REQ,
  output logic [31:0] o_IMEM_ADDR,
  input  logic        i_IMEM_ACK,
  input  logic        i_IMEM_ERR,
  input  logic [31:0] i_IMEM_DATA,
  output logic [31:0] o_INSTRUCTION,
  output logic        o_INSTRUCTION_VALID,
  output logic [31:0] o_FETCH_PC,
  output logic        o_FETCH_ERR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  fetch_state_e     state_p0, state_d;
  logic [31:0]      addr_p0, addr_d;
  logic [31:0]      instr_p0, instr_d;
  logic             err_p0, err_d;
  logic [CNT_W-1:0] cnt_p0, cnt_d;
  logic             timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_p0 == TO_LAST);

  always_comb begin
    state_d = state_p0;
    addr_d  = addr_p0;
    instr_d = instr_p0;
    err_d   = err_p0;
    cnt_d   = cnt_p0;
    case (state_p0)
      FETCH_IDLE: begin
        addr_d = i_PC;
        if (i_PC[1:0] != 2'b00) begin
          instr_d = NOOP;
          err_d   = 1'b1;
          state_d = FETCH_VALID;
        end else begin
          cnt_d   = '0;
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        // Error outranks ack so a faulted beat never leaks its data.
        if (i_IMEM_ERR) begin
          instr_d = NOOP;
          err_d   = 1'b1;
          state_d = FETCH_VALID;
        end else if (i_IMEM_ACK) begin
          instr_d = i_IMEM_DATA;
          err_d   = 1'b0;
          state_d = FETCH_VALID;
        end else if (timeout_hit) begin
          instr_d = NOOP;
          err_d   = 1'b1;
          state_d = FETCH_VALID;
        end else begin
          cnt_d = sat_inc(cnt_p0);
        end
      end
      FETCH_VALID: begin
        if (i_DECODE_READY) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // Stage p0: fetch state and held instruction registers
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state_p0 <= FETCH_IDLE;
      addr_p0  <= RESET_VECTOR;
      instr_p0 <= NOOP;
      err_p0   <= 1'b0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_d;
      addr_p0  <= addr_d;
      instr_p0 <= instr_d;
      err_p0   <= err_d;
      cnt_p0   <= cnt_d;
    end
  end

  assign o_IMEM_REQ          = (state_p0 == FETCH_REQ);
  assign o_IMEM_ADDR         = addr_p0;
  assign o_INSTRUCTION       = instr_p0;
  assign o_INSTRUCTION_VALID = (state_p0 == FETCH_VALID);
  assign o_FETCH_PC          = addr_p0;
  assign o_FETCH_ERR         = err_p0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a delivery scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] NOOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        ready = 1'b0;
  logic        ack = 1'b0;
  logic        berr = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        req;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        valid;
  logic [31:0] fpc;
  logic        ferr;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_CLK               (clk),
    .i_RSTn              (rst_n),
    .i_PC                (pc),
    .i_DECODE_READY      (ready),
    .o_IMEM_REQ          (req),
    .o_IMEM_ADDR         (addr),
    .i_IMEM_ACK          (ack),
    .i_IMEM_ERR          (berr),
    .i_IMEM_DATA         (rdata),
    .o_INSTRUCTION       (instr),
    .o_INSTRUCTION_VALID (valid),
    .o_FETCH_PC          (fpc),
    .o_FETCH_ERR         (ferr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req"},   32'(req),   32'd0);
    chk({tag, " addr"},  addr,       32'h0);
    chk({tag, " instr"}, instr,      NOOP);
    chk({tag, " valid"}, 32'(valid), 32'd0);
    chk({tag, " fpc"},   fpc,        32'h0);
    chk({tag, " ferr"},  32'(ferr),  32'd0);
  endtask

  task automatic expect_delivery(input string tag, input int bound);
    exp_t e;
    int   n = 0;
    while (!valid && n < bound) begin
      tick();
      n++;
    end
    chk({tag, " valid"}, 32'(valid), 32'd1);
    if (valid) begin
      chk({tag, " sb depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, " instr"}, instr,     e.instr);
        chk({tag, " fpc"},   fpc,       e.pc);
        chk({tag, " ferr"},  32'(ferr), 32'(e.err));
      end
    end else begin
      sb.delete();
    end
  endtask

  // Consume the held instruction and present a new PC; lands in IDLE.
  task automatic consume(input logic [31:0] next_pc);
    pc    = next_pc;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("consume valid drop", 32'(valid), 32'd0);
  endtask

  initial begin
    int reqs;

    // Reset state
    repeat (3) tick();
    chk_reset("reset");

    // Zero-wait fetch from address 0
    rst_n = 1'b1;
    tick();
    chk("t1 req", 32'(req), 32'd1);
    chk("t1 addr", addr, 32'h0);
    ack   = 1'b1;
    rdata = 32'h0050_0093;
    sb.push_back('{instr: 32'h0050_0093, pc: 32'h0, err: 1'b0});
    tick();
    ack = 1'b0;
    chk("t1 latency valid", 32'(valid), 32'd1);
    expect_delivery("t1", 0);

    // Decode stalls: outputs must hold, no new request
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2 stall req", 32'(req), 32'd0);
      chk("t2 stall valid", 32'(valid), 32'd1);
      chk("t2 stall instr", instr, 32'h0050_0093);
    end
    consume(32'h4);
    tick();
    chk("t2 req", 32'(req), 32'd1);
    chk("t2 addr", addr, 32'h4);
    tick();
    chk("t2 wait req", 32'(req), 32'd1);
    chk("t2 wait valid", 32'(valid), 32'd0);
    ack   = 1'b1;
    rdata = 32'h0010_8113;
    sb.push_back('{instr: 32'h0010_8113, pc: 32'h4, err: 1'b0});
    tick();
    ack = 1'b0;
    expect_delivery("t2", 0);

    // Misaligned PC: straight to VALID, bus untouched
    consume(32'h102);
    chk("t3 idle req", 32'(req), 32'd0);
    sb.push_back('{instr: NOOP, pc: 32'h102, err: 1'b1});
    tick();
    chk("t3 req", 32'(req), 32'd0);
    expect_delivery("t3", 0);

    // Timeout: request held exactly 4 cycles
    consume(32'h8);
    sb.push_back('{instr: NOOP, pc: 32'h8, err: 1'b1});
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req) reqs++;
      else break;
    end
    chk("t4 req cycles", 32'(reqs), 32'd4);
    expect_delivery("t4", 0);
    ack   = 1'b1;
    rdata = 32'hFFFF_FFFF;
    tick();
    ack = 1'b0;
    chk("t4 late ack instr", instr, NOOP);
    chk("t4 late ack ferr", 32'(ferr), 32'd1);
    chk("t4 late ack valid", 32'(valid), 32'd1);

    // Simultaneous ack and err: err wins
    consume(32'hC);
    tick();
    chk("t5 req", 32'(req), 32'd1);
    ack   = 1'b1;
    berr  = 1'b1;
    rdata = 32'hDEAD_BEEF;
    sb.push_back('{instr: NOOP, pc: 32'hC, err: 1'b1});
    tick();
    ack  = 1'b0;
    berr = 1'b0;
    expect_delivery("t5", 0);

    // Reset during REQ with a slow memory; its late ack must be ignored
    consume(32'h10);
    tick();
    chk("t6 req", 32'(req), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk_reset("t6 midreq");
    rst_n = 1'b1;
    ack   = 1'b1;
    rdata = 32'hAAAA_AAAA;
    tick();
    ack = 1'b0;
    chk("t6 stale valid", 32'(valid), 32'd0);
    chk("t6 stale instr", instr, NOOP);
    chk("t6 refetch req", 32'(req), 32'd1);
    chk("t6 refetch addr", addr, 32'h10);
    ack   = 1'b1;
    rdata = 32'h0000_0533;
    sb.push_back('{instr: 32'h0000_0533, pc: 32'h10, err: 1'b0});
    tick();
    ack = 1'b0;
    expect_delivery("t6", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
